serial_arb_shifter: RTL and testbench

Two-requester round-robin arbiter and sequencer for a shared parallel-load, serial-out shift register built from the team's clocked flip-flop chain. It grants one requester at a time and latches that requester's parallel word. It then shifts the word out MSB-first on a qualified serial line, and also presents a one-cycle-delayed copy of the serial bit for a downstream second register stage. It sits between parallel producers and a single-bit serial datapath.

---
 rtl/serial_arb_shifter.sv | 110 +++++++++++
 tb/tb_serial_arb_shifter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_arb_shifter.sv
// serial_arb_shifter: two-requester round-robin arbiter feeding a parallel-load,
// MSB-first serial shifter. Every output is registered; Sout_d is Sout delayed
// by one more cycle for a downstream second register stage.
module serial_arb_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Data0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Busy,
  output logic             Owner,
  output logic             Sout,
  output logic             Valid,
  output logic             Done,
  output logic             Sout_d
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             last, last_nx;
  logic             win;
  logic             gnt0_nx, gnt1_nx, busy_nx, owner_nx, sout_nx, valid_nx, done_nx;

  // Next-state and next-output decode: arbitration in IDLE, shifting in SHIFT.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    last_nx  = last;
    gnt0_nx  = 1'b0;
    gnt1_nx  = 1'b0;
    busy_nx  = 1'b0;
    owner_nx = Owner;
    sout_nx  = 1'b0;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    // On a tie the requester that was not granted last wins; otherwise the lone requester.
    win      = (Req0 && Req1) ? ~last : Req1;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          sreg_nx  = win ? Data1 : Data0;
          sout_nx  = sreg_nx[WIDTH-1];
          gnt0_nx  = ~win;
          gnt1_nx  = win;
          owner_nx = win;
          last_nx  = win;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = CW'(WIDTH - 1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          // Word fully presented; drop back to IDLE for one arbitration cycle.
          state_nx = IDLE;
        end else begin
          sreg_nx  = {sreg[WIDTH-2:0], 1'b0};
          sout_nx  = sreg[WIDTH-2];
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          done_nx  = (cnt == CW'(1));
          cnt_nx   = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      last   <= 1'b1;
      Gnt0   <= 1'b0;
      Gnt1   <= 1'b0;
      Busy   <= 1'b0;
      Owner  <= 1'b0;
      Sout   <= 1'b0;
      Valid  <= 1'b0;
      Done   <= 1'b0;
      Sout_d <= 1'b0;
    end else begin
      state  <= state_nx;
      sreg   <= sreg_nx;
      cnt    <= cnt_nx;
      last   <= last_nx;
      Gnt0   <= gnt0_nx;
      Gnt1   <= gnt1_nx;
      Busy   <= busy_nx;
      Owner  <= owner_nx;
      Sout   <= sout_nx;
      Valid  <= valid_nx;
      Done   <= done_nx;
      Sout_d <= Sout;
    end
  end
endmodule

// File: tb/tb_serial_arb_shifter.sv
// Bench for serial_arb_shifter: a transaction-level model predicts grant edges,
// winners and captured words; a monitor checks the DUT's serial stream per cycle.
module tb_serial_arb_shifter;
  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [W-1:0] Data0 = '0, Data1 = '0;
  logic         Gnt0, Gnt1, Busy, Owner, Sout, Valid, Done, Sout_d;

  serial_arb_shifter #(.WIDTH(W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(Req0), .Data0(Data0), .Req1(Req1), .Data1(Data1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Busy(Busy), .Owner(Owner),
    .Sout(Sout), .Valid(Valid), .Done(Done), .Sout_d(Sout_d)
  );

  always #5 Clock = ~Clock;

  int edge_n = 0;
  always @(posedge Clock) edge_n <= edge_n + 1;

  typedef struct {
    int           e;
    bit           w;
    logic [W-1:0] d;
  } xfer_t;
  xfer_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // ---------------- stimulus + reference model ----------------
  bit           rstn_v = 1'b0;
  bit           want0 = 1'b0, want1 = 1'b0;
  logic [W-1:0] dat0 = '0, dat1 = '0;
  bit           m_last = 1'b1;
  int           m_free = 0;

  // Apply inputs for the next edge and predict what the arbiter does there.
  task automatic step();
    int e;
    bit w;
    @(negedge Clock);
    Resetn = rstn_v;
    Req0 = want0; Req1 = want1;
    Data0 = dat0; Data1 = dat1;
    e = edge_n + 1;
    if (!rstn_v) begin
      m_last = 1'b1;
      m_free = e + 1;
    end else if (e >= m_free && (want0 || want1)) begin
      w = (want0 && want1) ? !m_last : want1;
      q.push_back('{e: e, w: w, d: (w ? dat1 : dat0)});
      m_last = w;
      m_free = e + W + 1;
      if (w) want1 = 1'b0; else want0 = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  int           pos = -1;
  xfer_t        cur;
  bit           prev_exp = 1'b0;
  bit           owner_exp = 1'b0;

  initial begin
    bit es, ev, ed, eb;
    forever begin
      @(posedge Clock);
      #1;
      if (!Resetn) begin
        chk("rst_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
        chk("rst_busy_valid_done", {29'd0, Busy, Valid, Done}, 32'd0);
        chk("rst_sout", {30'd0, Sout, Sout_d}, 32'd0);
        chk("rst_owner", {31'd0, Owner}, 32'd0);
        pos = -1; prev_exp = 1'b0; owner_exp = 1'b0;
      end else begin
        if (Gnt0 || Gnt1) begin
          if (q.size() == 0) begin
            chk("spurious_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
            pos = -1;
          end else begin
            cur = q.pop_front();
            chk("gnt_edge", edge_n, cur.e);
            chk("gnt_winner", {30'd0, Gnt1, Gnt0}, cur.w ? 32'd2 : 32'd1);
            owner_exp = cur.w;
            pos = 0;
          end
        end else begin
          if (q.size() > 0 && q[0].e <= edge_n) begin
            chk("gnt_missing", {30'd0, Gnt1, Gnt0}, q[0].w ? 32'd2 : 32'd1);
            void'(q.pop_front());
          end
          if (pos >= 0) begin
            pos++;
            if (pos == W) pos = -1;
          end
        end
        es = 1'b0; ev = 1'b0; ed = 1'b0; eb = 1'b0;
        if (pos >= 0) begin
          es = cur.d[W-1-pos];
          ev = 1'b1; eb = 1'b1;
          ed = (pos == W - 1);
        end
        chk("sout", {31'd0, Sout}, {31'd0, es});
        chk("valid", {31'd0, Valid}, {31'd0, ev});
        chk("done", {31'd0, Done}, {31'd0, ed});
        chk("busy", {31'd0, Busy}, {31'd0, eb});
        chk("owner", {31'd0, Owner}, {31'd0, owner_exp});
        chk("sout_d", {31'd0, Sout_d}, {31'd0, prev_exp});
        prev_exp = es;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset held two edges with both requesting.
    rstn_v = 1'b0; want0 = 1'b1; want1 = 1'b1;
    dat0 = 8'hF0; dat1 = 8'h0F;
    repeat (2) step();
    // Tie, back-to-back and fairness: both held high for four transfers.
    rstn_v = 1'b1;
    for (int i = 0; i < 4 * (W + 1) + 1; i++) begin
      want0 = 1'b1; want1 = 1'b1;
      step();
    end
    want0 = 1'b0; want1 = 1'b0;
    repeat (W + 2) step();

    // Single word.
    want0 = 1'b1; dat0 = 8'hA5;
    repeat (W + 3) step();

    // Data hold: word changes right after its grant edge.
    want0 = 1'b1; dat0 = 8'h81;
    step();
    dat0 = 8'h00;
    repeat (W + 2) step();

    // Mid-transfer reset at grant edge + 3, then Req1 held again.
    want1 = 1'b1; dat1 = 8'hFF;
    step();
    repeat (2) step();
    rstn_v = 1'b0;
    step();
    rstn_v = 1'b1; want1 = 1'b1;
    repeat (W + 3) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!want0 && ($urandom % 4 == 0)) want0 = 1'b1;
      if (!want1 && ($urandom % 4 == 0)) want1 = 1'b1;
      dat0 = W'($urandom);
      dat1 = W'($urandom);
      rstn_v = ($urandom % 250 != 0);
      step();
    end

    // Drain.
    rstn_v = 1'b1; want0 = 1'b0; want1 = 1'b0;
    repeat (W + 3) step();
    @(posedge Clock);
    #2;
    chk("queue_empty", q.size(), 32'd0);
    chk("idle_at_end", pos, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
